// File: rtl/pc_pkg.sv
// pc_pkg: shared defaults and the next-PC source enum for the fetch PC generator.
package pc_pkg;

  localparam int unsigned DEF_XLEN      = 32;
  localparam int unsigned DEF_INC       = 4;
  localparam int unsigned DEF_RAS_DEPTH = 4;

  // Next-PC source, listed in priority order (highest first)
  typedef enum logic [2:0] {
    REDIRECT,
    HOLD,
    CALL,
    RET,
    RET_MISS,
    JUMP,
    SEQ
  } npc_sel_t;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
// Ports: clk/rst (async active-high), push/pop requests, push_data,
//        top (most recent entry), count (valid entries), empty, full.
// push+pop together replaces the top entry (plain push when empty).
// Pushing when full overwrites the oldest entry; count saturates.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned XLEN  = DEF_XLEN,
  parameter int unsigned DEPTH = DEF_RAS_DEPTH,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic [CW-1:0]   count,
  output logic            empty,
  output logic            full
);

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   ptr;       // next free slot; top lives at ptr-1
  logic [PW-1:0]   top_idx;
  logic            replace;

  assign top_idx = ptr - PW'(1);
  assign top     = mem[top_idx];
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign replace = push && pop && !empty;

  // Pointer and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (replace) begin
      ptr   <= ptr;
      count <= count;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (pop && !empty) begin
      ptr   <= top_idx;
      count <= count - CW'(1);
    end
  end

  // Storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push) begin
      if (replace) mem[top_idx] <= push_data;
      else         mem[ptr]     <= push_data;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with fixed-priority next-PC select
// and return-address prediction.
// Ports: clk_i, rst_i (async active-high), stall_i, redirect_i/redirect_pc_i,
//        jump_i/jump_pc_i, call_i/link_pc_i, ret_i;
//        pc_o (registered fetch PC), ras_count_o (valid RAS entries),
//        ras_miss_o (registered pulse: ret accepted on an empty RAS).
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned     INC       = DEF_INC,
  parameter int unsigned     RAS_DEPTH = DEF_RAS_DEPTH,
  localparam int unsigned    CW        = $clog2(RAS_DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_pc_i,
  input  logic            call_i,
  input  logic [XLEN-1:0] link_pc_i,
  input  logic            ret_i,
  output logic [XLEN-1:0] pc_o,
  output logic [CW-1:0]   ras_count_o,
  output logic            ras_miss_o
);

  npc_sel_t        sel;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] ras_top;
  logic            ras_push;
  logic            ras_pop;
  logic            ras_empty;
  logic            ras_full;
  logic            miss_next;

  assign seq_pc = pc_o + XLEN'(INC);

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (link_pc_i),
    .top       (ras_top),
    .count     (ras_count_o),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  // Priority decode and next-PC mux
  always_comb begin
    sel       = SEQ;
    next_pc   = seq_pc;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    miss_next = 1'b0;

    if (redirect_i)    sel = REDIRECT;
    else if (stall_i)  sel = HOLD;
    else if (call_i)   sel = CALL;
    else if (ret_i)    sel = ras_empty ? RET_MISS : RET;
    else if (jump_i)   sel = JUMP;

    unique case (sel)
      REDIRECT: next_pc = redirect_pc_i;
      HOLD:     next_pc = pc_o;
      CALL: begin
        // call+ret together pops too, which the RAS treats as replace-top
        next_pc  = jump_pc_i;
        ras_push = 1'b1;
        ras_pop  = ret_i;
      end
      RET: begin
        next_pc = ras_top;
        ras_pop = 1'b1;
      end
      RET_MISS: begin
        next_pc   = seq_pc;
        miss_next = 1'b1;
      end
      JUMP:     next_pc = jump_pc_i;
      default:  next_pc = seq_pc;
    endcase
  end

  // PC and miss-flag registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_o       <= RESET_VEC;
      ras_miss_o <= 1'b0;
    end else begin
      pc_o       <= next_pc;
      ras_miss_o <= miss_next;
    end
  end

  // Occupancy and full flag must agree
  a_full_count: assert property (@(posedge clk_i) disable iff (rst_i)
    ras_full == (ras_count_o == CW'(RAS_DEPTH)));

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the pipelined CPU's fetch stage. It holds the fetch PC and selects the next PC by fixed priority: execute-stage redirect, then decode-stage call/return/jump, then sequential increment. A small circular return-address stack (RAS) predicts `ret` targets. It supersedes the fixed 32-bit stall-only PC register.

## Interface
Parameters:
- `XLEN`, 32: PC width in bits.
- `RESET_VEC`, 32'h0: PC value loaded on reset.
- `INC`, 4: sequential increment in bytes.
- `RAS_DEPTH`, 4: RAS entries; power of two, ≥2.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `stall_i`  in  1  hold the PC; hazard unit drives it.
- `redirect_i`  in  1  execute-stage mispredict or branch taken.
- `redirect_pc_i`  in  XLEN  redirect target.
- `jump_i`  in  1  decode-stage unconditional jump.
- `jump_pc_i`  in  XLEN  jump or call target.
- `call_i`  in  1  decode-stage call; implies a jump to `jump_pc_i`.
- `link_pc_i`  in  XLEN  return address pushed on a call.
- `ret_i`  in  1  decode-stage return.
- `pc_o`  out  XLEN  current fetch PC; registered.
- `ras_count_o`  out  clog2(RAS_DEPTH)+1  number of valid RAS entries.
- `ras_miss_o`  out  1  one-cycle pulse, registered: a `ret` was accepted while the RAS was empty.

## Operation
- Reset:
  - `pc_o`=RESET_VEC, `ras_count_o`=0, `ras_miss_o`=0.
  - RAS pointer=0. RAS contents are don't-care.
- Next-PC priority, highest first:
  1. `redirect_i`: next PC=`redirect_pc_i`. Overrides `stall_i`. Decode inputs are ignored. RAS is not changed (no repair).
  2. `stall_i`: PC holds. RAS holds. Decode inputs are ignored. `ras_miss_o`=0.
  3. `call_i`: push `link_pc_i`; next PC=`jump_pc_i`.
  4. `ret_i` with RAS non-empty: pop; next PC=popped top.
  5. `ret_i` with RAS empty: next PC=`pc_o`+INC; `ras_miss_o`=1 on the next cycle.
  6. `jump_i`: next PC=`jump_pc_i`.
  7. Otherwise: next PC=`pc_o`+INC, modulo 2^XLEN (wraps silently).
- `call_i` and `ret_i` together (co-routine swap):
  - Top entry is replaced by `link_pc_i`; count unchanged.
  - Next PC=`jump_pc_i`.
  - If the RAS is empty, this acts as a plain push.
- Push when full: overwrite the oldest entry (circular); count saturates at RAS_DEPTH.
- Pop: pointer decrements modulo RAS_DEPTH; count decrements.
- `jump_i` together with `call_i` or `ret_i`: the call/ret rule applies; `jump_i` is redundant.
- `ras_miss_o` is driven only by rule 5; it is 0 in every other cycle.
- PC bits are never force-aligned; alignment checking belongs downstream.

## Timing
- `pc_o` changes only on a rising edge, or asynchronously on reset assertion. There are no combinational paths from inputs to outputs.
- Redirect latency: 1 cycle. An input sampled at edge N appears on `pc_o` after edge N.
- Push/pop become visible on `ras_count_o` in the same cycle as the new `pc_o`.
- A pop followed immediately by a push, and a push followed immediately by a pop, both work back-to-back with no bubble.
- Reset asserted mid-operation:
  - `pc_o`, count, and miss clear immediately.
  - Decode and redirect inputs are ignored while `rst_i`=1.
  - The first edge after release loads the normal next PC from RESET_VEC.

## Structure
- Package `pc_pkg`:
  - `npc_sel_t` enum: REDIRECT, HOLD, CALL, RET, RET_MISS, JUMP, SEQ.
  - Default localparams for XLEN, INC, RAS_DEPTH.
- Sub-module `pc_ras`:
  - Circular stack: storage array, pointer, count.
  - Ports: push, pop, push data, top, count, empty, full.
  - Handles push+pop as replace-top.
- `pc_gen` holds the priority decoder, the PC register, and the miss flag.

## Test plan
- Reset with RESET_VEC=32'h100, no inputs, 3 edges → `pc_o` = 0x100, 0x104, 0x108, 0x10C.
- Assert `stall_i` and `redirect_i`(0x2000) together → `pc_o`=0x2000 next cycle. Then stall alone for 2 cycles → `pc_o` stays 0x2000.
- RAS_DEPTH=4:
  - Five calls with link 0x10, 0x20, 0x30, 0x40, 0x50 → count=4.
  - Four rets → `pc_o` = 0x50, 0x40, 0x30, 0x20.
  - Fifth ret → `pc_o`=prev+4, `ras_miss_o` pulses 1 cycle.
- Call (link 0x44, target 0x800) and ret in the same cycle with top=0x30 → `pc_o`=0x800, count unchanged. Next ret → `pc_o`=0x44.
- `pc_o`=32'hFFFFFFFC, sequential → `pc_o`=0x0.
- Call accepted, then `rst_i` pulsed mid-cycle → `pc_o`=RESET_VEC and count=0 immediately. A ret after release → `ras_miss_o`=1.
